mp_adder_seq: RTL
=================

// Module: mp_adder_seq
// PURPOSE
//  Sequential multi-precision adder stage directly downstream of addern: feeds one WIDTH-bit limb pair per
//  beat into an addern instance, captures its cout in a carry register and chains it into the next limb's cin.
//  Produces a stream of sum limbs (LSB limb first) plus the final carry-out for operands up to MAXLEN limbs.
//  Sits between the operand sequencer and the result writeback in the ALU datapath.
// PARAMETERS
//  WIDTH   8    limb width in bits; passed straight to addern #(WIDTH)
//  MAXLEN  16   maximum limbs per operation
//  LEN_W   4    width of len port; clog2(MAXLEN)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous active-high reset
//  start      in   1       begin operation; sampled only in IDLE
//  len        in   LEN_W   limb count minus one (0 = 1 limb); captured with start
//  cin_init   in   1       carry into limb 0; captured with start
//  in_valid   in   1       a/b limb pair valid
//  in_ready   out  1       stage can accept a limb pair this cycle
//  a          in   WIDTH   operand A limb
//  b          in   WIDTH   operand B limb
//  out_valid  out  1       sum limb valid
//  out_ready  in   1       consumer accepts sum limb
//  sum        out  WIDTH   sum limb, registered
//  last       out  1       qualifies sum: final limb of operation
//  cout       out  1       final carry-out; valid when done pulses, held until next start
//  busy       out  1       high in RUN or DRAIN
//  done       out  1       one-cycle pulse when last limb is handed off
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready, out_valid, sum, last, cout, busy, done all 0; carry reg and limb count 0.
//  - States: IDLE -> RUN on start (latch len, carry<=cin_init, count<=0, cout<=0).
//    RUN -> DRAIN when the limb with count==len is accepted. DRAIN -> IDLE when out_valid&&out_ready; done=1
//    that same cycle, cout<=carry. start outside IDLE is ignored and len/cin_init are not re-captured.
//  - in_ready = (state==RUN) && (!out_valid || out_ready). The single output register may be overwritten
//    on the cycle it is drained: full throughput, one limb per cycle.
//  - Accept (in_valid&&in_ready): addern(a, b, cin=carry) -> sum<=s, carry<=addern.cout, out_valid<=1,
//    last<=(count==len), count<=count+1. Latency: one cycle, accepted pair to out_valid.
//  - out_valid&&out_ready with no accept that cycle: out_valid<=0. sum and last hold while out_valid&&!out_ready.
//  - Arithmetic: per-limb modulo 2^WIDTH, carry exactly 1 bit. len==MAXLEN-1 is the maximum; count never
//    wraps because RUN exits at count==len.
//  - in_valid outside RUN is ignored; a/b are don't-care.
//  - Reset mid-operation: abandons the operation immediately and clears all state, including a pending out_valid.
//  - done and a new start may occur on consecutive cycles (IDLE lasts >=1 cycle). cout is stable from done
//    until the next accepted start.
// STRUCTURE
//  - Shared include nandy_defs.vh: state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
//  - One sub-module: addern #(WIDTH), carry input driven from the carry register. No other adder logic.
//  - The 2-bit state register, count/len registers, carry register and output register live in this module.
// TESTING
//  1. len=0, cin_init=0, a=8'hFF, b=8'h01 -> one beat: sum=8'h00, last=1; done pulse; cout=1.
//  2. len=1, limbs (FF,01),(00,00) -> sums 8'h00 then 8'h01, last on the 2nd beat only; cout=0.
//  3. len=3, all limbs FF+00, cin_init=1 -> four sums of 8'h00; cout=1.
//  4. Backpressure: len=2, out_ready=0 for 3 cycles after the first accept -> in_ready=0, sum held;
//     results match the no-stall run.
//  5. rst during RUN after 2 of 4 limbs -> next cycle out_valid=0, busy=0; a fresh start runs cleanly.
//  6. start pulsed during RUN with len=0 -> ignored; the original len completes. Then 181-seed random
//     16-bit ops vs a+b reference, 2 limbs each.

Source files
------------

// File: rtl/mp_adder_seq_pkg.sv
// mp_adder_seq_pkg: shared state encoding for the multi-precision adder stage
package mp_adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mp_adder_seq_addern.sv
// mp_adder_seq_addern: WIDTH-bit ripple adder with carry in and carry out
module mp_adder_seq_addern #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mp_adder_seq.sv
// mp_adder_seq: streams limb pairs through one adder, chaining the carry limb to limb
module mp_adder_seq
    import mp_adder_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MAXLEN = 16,
    parameter int LEN_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             cin_init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             last,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic             carry;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             accept;
    logic             fin;
    logic             drain;

    mp_adder_seq_addern #(.WIDTH(WIDTH)) u_add (
        .a    (a),
        .b    (b),
        .cin  (carry),
        .s    (s),
        .cout (co)
    );

    // the output register may be refilled in the same cycle it is drained
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign fin      = count == len_q;
    assign busy     = state != IDLE;

    // operation FSM with carry chain, limb counter and registered output limb
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            carry     <= 1'b0;
            count     <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            last      <= 1'b0;
            cout      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (drain)
                out_valid <= 1'b0;
            if (accept) begin
                sum       <= s;
                carry     <= co;
                out_valid <= 1'b1;
                last      <= fin;
                count     <= count + 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    len_q <= (len > LEN_W'(MAXLEN - 1)) ? LEN_W'(MAXLEN - 1) : len;
                    carry <= cin_init;
                    count <= '0;
                    cout  <= 1'b0;
                end
                RUN: if (accept && fin)
                    state <= DRAIN;
                DRAIN: if (drain) begin
                    state <= IDLE;
                    done  <= 1'b1;
                    cout  <= carry;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
